// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants and types for the dual-port-RAM FIFO controller and its output buffer.
package dpram_fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int unsigned LEVEL_WIDTH    = DEF_ADDR_WIDTH + 2;

    // Output buffer covers the RAM's one-cycle read latency plus one word of slack.
    localparam int unsigned OUT_DEPTH      = 2;
    localparam int unsigned OUT_CNT_WIDTH  = $clog2(OUT_DEPTH + 1);

    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/dpram_fifo_outbuf.sv
// Two-entry output FIFO that captures RAM read data and presents the head word downstream.
module dpram_fifo_outbuf
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     pop,
    output logic [OUT_CNT_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0]    head
);

    logic [DATA_WIDTH-1:0]    head_q, head_d;
    logic [DATA_WIDTH-1:0]    tail_q, tail_d;
    logic [OUT_CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (count_q == '0) begin
                        head_d = wr_data;
                    end else begin
                        tail_d = wr_data;
                    end
                    count_d = count_q + OUT_CNT_WIDTH'(1);
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - OUT_CNT_WIDTH'(1);
                end
                2'b11: begin
                    // Shift the head out and append the captured word behind it.
                    if (count_q == OUT_CNT_WIDTH'(1)) begin
                        head_d = wr_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port A writes the input stream, port B reads into
// a small output buffer so the output stream runs at full rate despite the RAM read latency.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = ADDR_WIDTH + 1;
    localparam int unsigned LvlW  = ADDR_WIDTH + 2;
    localparam int unsigned PendW = OUT_CNT_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          mem_count_q, mem_count_d;
    logic                     inflight_q, inflight_d;
    logic                     rst_done_q;
    logic [OUT_CNT_WIDTH-1:0] out_cnt;
    logic [PendW-1:0]         out_pending;
    logic                     full_int;
    logic                     push;
    logic                     pop;
    logic                     rd_issue;
    logic [LvlW-1:0]          level_int;

    assign full_int = (mem_count_q == CntW'(Depth));
    assign s_ready  = rst_done_q & ~full_int;
    assign push     = s_valid & s_ready & ~clr;
    assign m_valid  = (out_cnt != '0);
    assign pop      = m_valid & m_ready;

    // Words that will occupy the output buffer after this edge if no new read is issued.
    assign out_pending = PendW'(out_cnt) + PendW'(inflight_q) - PendW'(pop);
    assign rd_issue    = (mem_count_q != '0) & (out_pending < PendW'(OUT_DEPTH)) & ~clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        inflight_d  = 1'b0;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            mem_count_d = mem_count_q + CntW'(push) - CntW'(rd_issue);
            inflight_d  = rd_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            rst_done_q  <= 1'b1;
        end
    end

    // RAM data is only sampled while a read is in flight, so post-reset X never enters.
    dpram_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (inflight_q),
        .wr_data (ram_q_b),
        .pop     (pop),
        .count   (out_cnt),
        .head    (m_data)
    );

    assign ram_addr_a = wr_ptr_q;
    assign ram_data_a = s_data;
    assign ram_we_a   = push;
    assign ram_addr_b = rd_ptr_q;
    assign ram_we_b   = 1'b0;

    assign level_int = LvlW'(mem_count_q) + LvlW'(inflight_q) + LvlW'(out_cnt);
    assign level     = level_int;
    assign full      = full_int;
    assign empty     = (level_int == '0);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural dual-port RAM on the ram_* ports.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_ctrl_pkg::*;

    localparam int unsigned DW = DEF_DATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr;
    logic                   s_valid;
    logic                   s_ready;
    logic [DW-1:0]          s_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [DW-1:0]          m_data;
    ptr_t                   ram_addr_a;
    logic [DW-1:0]          ram_data_a;
    logic                   ram_we_a;
    ptr_t                   ram_addr_b;
    logic                   ram_we_b;
    logic [DW-1:0]          ram_q_b;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   full;
    logic                   empty;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (DEF_ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    // Dual-port RAM model: write on A, registered read on B.
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= ram_mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples handshakes mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("level_vs_model", 32'(level), 32'(exp_q.size()));
            check("empty_vs_model", 32'(empty), 32'(exp_q.size() == 0));
            check("ram_we_b_zero", 32'(ram_we_b), 32'd0);
            check("ram_we_a_is_push", 32'(ram_we_a), 32'(s_valid && s_ready && !clr));
            if (clr) begin
                exp_q.delete();
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_with_empty_model", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                end
                if (s_valid && s_ready) exp_q.push_back(s_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int k = 0;
        while ((level != '0 || exp_q.size() != 0) && k < bound) begin
            tick();
            k++;
        end
        check({name, "_drained_level"}, 32'(level), 32'd0);
        check({name, "_drained_model"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        int  accepted;

        rst_n   = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset values
        #2;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_ram_we_a", 32'(ram_we_a), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #1;
        check("rst_done_pending", 32'(s_ready), 32'd0);
        tick();
        check("rst_done_s_ready", 32'(s_ready), 32'd1);

        // 1: single word latency
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        lat     = 0;
        seen    = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (k == 1) s_valid = 1'b0;
            if (m_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_data", 32'(m_data), 32'hA5);
        tick();
        check("t1_level", 32'(level), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // 2: 40-word stream at full rate, valid window is cycles 3..42
        for (int c = 0; c < 50; c++) begin
            s_valid = (c < 40);
            s_data  = DW'(c);
            if (c < 40) check("t2_s_ready", 32'(s_ready), 32'd1);
            check("t2_m_valid", 32'(m_valid), 32'((c >= 3) && (c < 43)));
            tick();
        end
        s_valid = 1'b0;
        wait_drain(20, "t2");

        // 3: backpressure fill to DEPTH+2 then drain
        m_ready  = 1'b0;
        accepted = 0;
        for (int n = 0; n < 40; n++) begin
            s_valid = 1'b1;
            s_data  = DW'(n * 7 + 3);
            if (!s_ready) break;
            accepted++;
            tick();
        end
        s_valid = 1'b0;
        check("t3_accepted", 32'(accepted), 32'(DEPTH + 2));
        check("t3_full", 32'(full), 32'd1);
        check("t3_level", 32'(level), 32'(DEPTH + 2));
        m_ready = 1'b1;
        check("t3_s_ready_still_low", 32'(s_ready), 32'd0);
        tick();
        check("t3_s_ready_reassert", 32'(s_ready), 32'd1);
        wait_drain(40, "t3");

        // 4: random valid/ready
        for (int c = 0; c < 1000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drain(60, "t4");

        // 5: clr with concurrent push and pop
        m_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'h50 + n);
            tick();
        end
        clr     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        m_ready = 1'b1;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        check("t5_level_after_clr", 32'(level), 32'd0);
        check("t5_m_valid_after_clr", 32'(m_valid), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        seen    = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            tick();
            if (k == 1) s_valid = 1'b0;
            if (m_valid) seen = 1'b1;
        end
        check("t5_seen", 32'(seen), 32'd1);
        check("t5_data", 32'(m_data), 32'h3C);
        wait_drain(10, "t5");

        // 6: asynchronous reset mid-stream
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'hC0 + c);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_m_valid_async", 32'(m_valid), 32'd0);
        check("t6_s_ready_async", 32'(s_ready), 32'd0);
        check("t6_ram_we_a_async", 32'(ram_we_a), 32'd0);
        check("t6_level_async", 32'(level), 32'd0);
        exp_q.delete();
        tick();
        tick();
        #2;
        s_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("t6_s_ready_before_edge", 32'(s_ready), 32'd0);
        tick();
        check("t6_s_ready_after_edge", 32'(s_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("t6_no_stale", 32'(m_valid), 32'd0);
            tick();
        end
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        s_valid = 1'b0;
        wait_drain(10, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
